reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/cpu_pkg.sv | 12 +
 rtl/reg_scoreboard.sv | 76 +++++++
 rtl/reg_file_sb.sv | 82 ++++++++
 tb/tb_reg_file_sb.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg -- shared register-file defaults for the CPU core slice.
// Rev 1.0 -- initial release
// ============================================================================
package cpu_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;
  localparam int NUM_WR     = 2;
endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// reg_scoreboard -- pending-write tracking with RAW/WAW hazard flags.
// Rev 1.0 -- initial release
// ============================================================================
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR-1:0]        wr_clr_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic                     iss_valid_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  output logic                     iss_stall_o,
  output logic [(1<<ADDR_W)-1:0]   busy_vec_o,
  output logic [ADDR_W:0]          pend_cnt_o
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] w_clr, w_set, w_busy_live;
  logic [ADDR_W:0]  pend_cnt_q, pend_cnt_d;

  function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + {{ADDR_W{1'b0}}, v[i]};
    return c;
  endfunction

  always_comb begin
    w_clr = '0;
    for (int p = 0; p < NUM_WR; p++)
      if (wr_en_i[p] && wr_clr_i[p]) w_clr[wr_addr_i[p*ADDR_W +: ADDR_W]] = 1'b1;
    w_clr[0] = 1'b0;
  end

  // Retiring writes hide their busy bit in the same cycle so consumers need not wait.
  assign w_busy_live = busy_q & ~w_clr;
  assign iss_stall_o = iss_valid_i & w_busy_live[iss_addr_i];

  always_comb begin
    w_set = '0;
    if (iss_valid_i && !iss_stall_o && iss_addr_i != '0) w_set[iss_addr_i] = 1'b1;
  end

  assign busy_d     = w_busy_live | w_set;
  assign pend_cnt_d = popcount(busy_d);

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_busy
      assign rd_busy_o[k] = w_busy_live[rd_addr_i[k*ADDR_W +: ADDR_W]];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign busy_vec_o = busy_q;
  assign pend_cnt_o = pend_cnt_q;
endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// reg_file_sb -- multi-read, dual-write register file with bypass and scoreboard.
// Rev 1.0 -- initial release
// ============================================================================
module reg_file_sb
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [1:0]               wr_en,
  input  logic [2*ADDR_W-1:0]      wr_addr,
  input  logic [2*DATA_W-1:0]      wr_data,
  input  logic [1:0]               wr_clr,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_stall,
  output logic [(1<<ADDR_W)-1:0]   busy_vec,
  output logic [ADDR_W:0]          pend_cnt
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];

  // Port 1 (load) is applied last so it wins an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++)
        if (wr_en[p] && wr_addr[p*ADDR_W +: ADDR_W] != '0)
          regs_q[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
    end
  end

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_a;
      logic              w_hit0, w_hit1;
      logic [DATA_W-1:0] w_rd;

      assign w_a    = rd_addr[k*ADDR_W +: ADDR_W];
      assign w_hit0 = wr_en[0] && (wr_addr[0 +: ADDR_W] == w_a);
      assign w_hit1 = wr_en[1] && (wr_addr[ADDR_W +: ADDR_W] == w_a);

      always_comb begin
        w_rd = regs_q[w_a];
        if (!rst_n || w_a == '0) w_rd = '0;
        else if (w_hit1)         w_rd = wr_data[DATA_W +: DATA_W];
        else if (w_hit0)         w_rd = wr_data[0 +: DATA_W];
      end

      assign rd_data[k*DATA_W +: DATA_W] = w_rd;
    end
  endgenerate

  reg_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr_i   (rd_addr),
    .rd_busy_o   (rd_busy),
    .wr_en_i     (wr_en),
    .wr_clr_i    (wr_clr),
    .wr_addr_i   (wr_addr),
    .iss_valid_i (iss_valid),
    .iss_addr_i  (iss_addr),
    .iss_stall_o (iss_stall),
    .busy_vec_o  (busy_vec),
    .pend_cnt_o  (pend_cnt)
  );
endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// tb_reg_file_sb -- directed scenarios plus randomized run against a reference model.
// Rev 1.0 -- initial release
// ============================================================================
module tb_reg_file_sb;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [1:0]               wr_en, wr_clr;
  logic [2*ADDR_W-1:0]      wr_addr;
  logic [2*DATA_W-1:0]      wr_data;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     iss_stall;
  logic [DEPTH-1:0]         busy_vec;
  logic [ADDR_W:0]          pend_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] m_regs [DEPTH];
  bit                m_busy [DEPTH];

  reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_stall(iss_stall),
    .busy_vec(busy_vec), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  function automatic int wa(int p);
    return int'(wr_addr[p*ADDR_W +: ADDR_W]);
  endfunction

  function automatic logic [DATA_W-1:0] wd(int p);
    return wr_data[p*DATA_W +: DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] m_read(int a);
    if (!rst_n || a == 0) return '0;
    if (wr_en[1] && wa(1) == a) return wd(1);
    if (wr_en[0] && wa(0) == a) return wd(0);
    return m_regs[a];
  endfunction

  function automatic bit m_clears(int a);
    if (a == 0) return 1'b0;
    for (int p = 0; p < 2; p++)
      if (wr_en[p] && wr_clr[p] && wa(p) == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_rbusy(int a);
    return m_busy[a] && !m_clears(a);
  endfunction

  function automatic bit m_stall();
    return iss_valid && m_rbusy(int'(iss_addr));
  endfunction

  function automatic int m_pend();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [DEPTH-1:0] m_vec();
    logic [DEPTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    rd_addr = '0; wr_en = '0; wr_clr = '0; wr_addr = '0; wr_data = '0;
    iss_valid = 1'b0; iss_addr = '0;
  endtask

  task automatic set_wr(int p, bit en, bit clr, int a, logic [DATA_W-1:0] d);
    wr_en[p]                   = en;
    wr_clr[p]                  = clr;
    wr_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
    wr_data[p*DATA_W +: DATA_W] = d;
  endtask

  task automatic set_rd(int k, int a);
    rd_addr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  task automatic issue(int a);
    iss_valid = 1'b1;
    iss_addr  = ADDR_W'(a);
  endtask

  // Advance one clock and apply the architectural effect of the inputs seen at the edge.
  task automatic clock();
    bit st;
    st = m_stall();
    @(posedge clk);
    if (rst_n) begin
      for (int p = 0; p < 2; p++)
        if (wr_en[p] && wa(p) != 0) m_regs[wa(p)] = wd(p);
      for (int a = 1; a < DEPTH; a++)
        if (m_clears(a)) m_busy[a] = 1'b0;
      if (iss_valid && !st && iss_addr != '0) m_busy[iss_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    set_wr(0, 1, 0, 3, 32'h55);
    issue(12);
    clock();
    idle();
    set_rd(0, 3);
    #1;
    n_cmp++; if (rd_data[0 +: DATA_W] !== 32'h55) begin n_bad++;
      $display("FAIL reset_pre_r3: got %h want %h", rd_data[0 +: DATA_W], 32'h55); end
    n_cmp++; if (pend_cnt !== 6'd1) begin n_bad++;
      $display("FAIL reset_pre_pend: got %0d want 1", pend_cnt); end
    set_wr(0, 1, 0, 3, 32'h77);
    issue(3);
    rst_n = 1'b0;
    m_reset();
    #1;
    n_cmp++; if (rd_data[0 +: DATA_W] !== '0) begin n_bad++;
      $display("FAIL reset_rd_data: got %h want 0", rd_data[0 +: DATA_W]); end
    n_cmp++; if (busy_vec !== '0 || pend_cnt !== '0) begin n_bad++;
      $display("FAIL reset_sb: got busy %h cnt %0d want 0/0", busy_vec, pend_cnt); end
    n_cmp++; if (rd_busy !== '0 || iss_stall !== 1'b0) begin n_bad++;
      $display("FAIL reset_flags: got rd_busy %b stall %b want 0/0", rd_busy, iss_stall); end
    clock();
    clock();
    #2;
    rst_n = 1'b1;
    idle();
    set_rd(0, 3);
    clock();
    n_cmp++; if (rd_data[0 +: DATA_W] !== '0 || busy_vec !== '0) begin n_bad++;
      $display("FAIL reset_after: got r3 %h busy %h want 0/0", rd_data[0 +: DATA_W], busy_vec); end
  endtask

  task automatic test_bypass();
    idle();
    set_wr(0, 1, 0, 5, 32'h1234);
    set_rd(0, 5);
    #1;
    n_cmp++; if (rd_data[0 +: DATA_W] !== 32'h1234) begin n_bad++;
      $display("FAIL bypass_same_cycle: got %h want 1234", rd_data[0 +: DATA_W]); end
    clock();
    idle();
    set_rd(0, 5);
    #1;
    n_cmp++; if (rd_data[0 +: DATA_W] !== 32'h1234) begin n_bad++;
      $display("FAIL bypass_array: got %h want 1234", rd_data[0 +: DATA_W]); end
  endtask

  task automatic test_zero_reg();
    idle();
    set_wr(0, 1, 0, 0, 32'hFFFF_FFFF);
    set_wr(1, 1, 1, 0, 32'hFFFF_FFFF);
    issue(0);
    #1;
    n_cmp++; if (rd_data[0 +: DATA_W] !== '0 || iss_stall !== 1'b0) begin n_bad++;
      $display("FAIL zero_read: got %h stall %b want 0/0", rd_data[0 +: DATA_W], iss_stall); end
    clock();
    idle();
    #1;
    n_cmp++; if (busy_vec[0] !== 1'b0 || pend_cnt !== '0 || rd_data[0 +: DATA_W] !== '0) begin n_bad++;
      $display("FAIL zero_sb: got busy0 %b cnt %0d rd %h want 0/0/0", busy_vec[0], pend_cnt, rd_data[0 +: DATA_W]); end
  endtask

  task automatic test_port_conflict();
    idle();
    set_wr(0, 1, 0, 7, 32'hA);
    set_wr(1, 1, 0, 7, 32'hB);
    set_rd(1, 7);
    #1;
    n_cmp++; if (rd_data[DATA_W +: DATA_W] !== 32'hB) begin n_bad++;
      $display("FAIL conflict_bypass: got %h want b", rd_data[DATA_W +: DATA_W]); end
    clock();
    idle();
    set_rd(1, 7);
    #1;
    n_cmp++; if (rd_data[DATA_W +: DATA_W] !== 32'hB) begin n_bad++;
      $display("FAIL conflict_store: got %h want b", rd_data[DATA_W +: DATA_W]); end
  endtask

  task automatic test_scoreboard();
    idle();
    issue(9);
    #1;
    n_cmp++; if (iss_stall !== 1'b0) begin n_bad++;
      $display("FAIL sb_first_issue: got stall %b want 0", iss_stall); end
    clock();
    n_cmp++; if (busy_vec[9] !== 1'b1 || pend_cnt !== 6'd1) begin n_bad++;
      $display("FAIL sb_set: got busy9 %b cnt %0d want 1/1", busy_vec[9], pend_cnt); end
    #1;
    n_cmp++; if (iss_stall !== 1'b1) begin n_bad++;
      $display("FAIL sb_waw: got stall %b want 1", iss_stall); end
    clock();
    n_cmp++; if (pend_cnt !== 6'd1) begin n_bad++;
      $display("FAIL sb_waw_cnt: got %0d want 1", pend_cnt); end
    idle();
    set_rd(0, 9);
    set_wr(0, 0, 1, 9, 32'h0);
    #1;
    n_cmp++; if (rd_busy[0] !== 1'b1) begin n_bad++;
      $display("FAIL sb_clr_no_en: got rd_busy %b want 1", rd_busy[0]); end
    clock();
    n_cmp++; if (busy_vec[9] !== 1'b1) begin n_bad++;
      $display("FAIL sb_clr_no_en_keep: got busy9 %b want 1", busy_vec[9]); end
    idle();
    set_rd(0, 9);
    set_wr(1, 1, 1, 9, 32'hCAFE);
    #1;
    n_cmp++; if (rd_busy[0] !== 1'b0 || rd_data[0 +: DATA_W] !== 32'hCAFE) begin n_bad++;
      $display("FAIL sb_clr_same_cycle: got rd_busy %b data %h want 0/cafe", rd_busy[0], rd_data[0 +: DATA_W]); end
    clock();
    n_cmp++; if (pend_cnt !== '0 || busy_vec[9] !== 1'b0) begin n_bad++;
      $display("FAIL sb_clr_next: got cnt %0d busy9 %b want 0/0", pend_cnt, busy_vec[9]); end
  endtask

  task automatic test_set_clear_collision();
    idle();
    issue(4);
    clock();
    idle();
    set_wr(0, 1, 1, 4, 32'h44);
    issue(4);
    #1;
    n_cmp++; if (iss_stall !== 1'b0) begin n_bad++;
      $display("FAIL coll_stall: got %b want 0", iss_stall); end
    clock();
    n_cmp++; if (busy_vec[4] !== 1'b1 || pend_cnt !== 6'd1) begin n_bad++;
      $display("FAIL coll_set_wins: got busy4 %b cnt %0d want 1/1", busy_vec[4], pend_cnt); end
    idle();
    set_wr(0, 1, 1, 4, 32'h44);
    clock();
    idle();
  endtask

  function automatic int rand_addr();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH-1)) : int'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      idle();
      for (int k = 0; k < NUM_RD; k++) set_rd(k, rand_addr());
      for (int p = 0; p < 2; p++)
        set_wr(p, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rand_addr(), $urandom());
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_addr  = ADDR_W'(rand_addr());
      #1;
      for (int k = 0; k < NUM_RD; k++) begin
        int a;
        a = int'(rd_addr[k*ADDR_W +: ADDR_W]);
        n_cmp++; if (rd_data[k*DATA_W +: DATA_W] !== m_read(a)) begin n_bad++;
          $display("FAIL rand_rd_data[%0d] cyc %0d: got %h want %h", k, cyc, rd_data[k*DATA_W +: DATA_W], m_read(a)); end
        n_cmp++; if (rd_busy[k] !== m_rbusy(a)) begin n_bad++;
          $display("FAIL rand_rd_busy[%0d] cyc %0d: got %b want %b", k, cyc, rd_busy[k], m_rbusy(a)); end
      end
      n_cmp++; if (iss_stall !== m_stall()) begin n_bad++;
        $display("FAIL rand_stall cyc %0d: got %b want %b", cyc, iss_stall, m_stall()); end
      clock();
      n_cmp++; if (busy_vec !== m_vec() || int'(pend_cnt) != m_pend()) begin n_bad++;
        $display("FAIL rand_sb cyc %0d: got busy %h cnt %0d want %h %0d", cyc, busy_vec, pend_cnt, m_vec(), m_pend()); end
    end
  endtask

  initial begin
    idle();
    m_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    clock();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_port_conflict();
    test_scoreboard();
    test_set_clear_collision();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
